// File: rtl/pattern_scheduler.sv
// pattern_scheduler: round sequencer that primes and refills pattern rows, paces row steps and tallies score/level
module pattern_scheduler #(
  parameter int          N_SLOTS    = 4,
  parameter int          TICK_DIV   = 200000,
  parameter int          LEVEL_STEP = 10,
  parameter int          MAX_LEVEL  = 7,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic               CLOCK_25,
  input  logic               reset,
  input  logic               start,
  input  logic [N_SLOTS-1:0] req,
  input  logic [N_SLOTS-1:0] ponto,
  output logic [N_SLOTS-1:0] grant,
  output logic [3:0]         pattern_out,
  output logic               step_tick,
  output logic [15:0]        score,
  output logic [2:0]         level,
  output logic               running
);
  localparam int PW = $clog2(N_SLOTS);
  localparam int LW = $clog2(N_SLOTS + 1);
  localparam int CW = $clog2(TICK_DIV + 1);
  localparam int AW = $clog2(LEVEL_STEP + N_SLOTS);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t             state, state_nx;
  logic [N_SLOTS-1:0] pending, pending_nx, grant_nx, cand, sel_oh;
  logic [PW-1:0]      rr_ptr, rr_nx, sel_idx;
  logic               sel_found;
  logic [LW-1:0]      load_idx, load_nx;
  logic [15:0]        lfsr, lfsr_nx, lfsr_adv;
  logic [3:0]         pat, pattern_nx, pc;
  logic [CW-1:0]      tick_cnt, tick_nx, period;
  logic [AW-1:0]      lvl_acc, acc_nx, acc_sum;
  logic [16:0]        score_sum;
  logic [15:0]        score_nx;
  logic [2:0]         level_nx;

  assign running   = state == RUN;
  assign lfsr_adv  = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign pat       = |lfsr[3:0] ? lfsr[3:0] : 4'b0001 << lfsr[5:4];
  assign period    = CW'(TICK_DIV) - CW'(level) * CW'(TICK_DIV >> 4);
  assign step_tick = running && tick_cnt >= period - CW'(1);
  assign cand      = pending | req;
  assign sel_oh    = N_SLOTS'(1) << sel_idx;
  assign score_sum = {1'b0, score} + 17'(pc);
  assign acc_sum   = lvl_acc + AW'(pc);

  // count hit pulses this cycle
  always_comb begin
    pc = '0;
    for (int i = 0; i < N_SLOTS; i++) pc = pc + 4'(ponto[i]);
  end

  // round-robin search for the first requesting row at or after rr_ptr
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 0; k < N_SLOTS; k++)
      if (!sel_found && cand[(int'(rr_ptr) + k) % N_SLOTS]) begin
        sel_found = 1'b1;
        sel_idx   = PW'((int'(rr_ptr) + k) % N_SLOTS);
      end
  end

  // next-state, grant, pacing and scoring decisions
  always_comb begin
    state_nx   = state;
    grant_nx   = '0;
    pattern_nx = '0;
    pending_nx = pending;
    rr_nx      = rr_ptr;
    load_nx    = load_idx;
    lfsr_nx    = lfsr;
    tick_nx    = tick_cnt;
    acc_nx     = lvl_acc;
    score_nx   = score;
    level_nx   = level;
    if (state == IDLE) begin
      if (start) begin
        state_nx = LOAD;
        grant_nx = N_SLOTS'(1);
        load_nx  = LW'(1);
      end
    end else if (state == LOAD) begin
      if (load_idx == LW'(N_SLOTS)) state_nx = RUN;
      else begin
        grant_nx = N_SLOTS'(1) << load_idx;
        load_nx  = load_idx + 1'b1;
      end
      pending_nx = cand & ~grant_nx;
    end else begin
      grant_nx   = sel_found ? sel_oh : '0;
      rr_nx      = !sel_found ? rr_ptr : sel_idx == PW'(N_SLOTS - 1) ? '0 : sel_idx + 1'b1;
      pending_nx = cand & ~grant_nx;
      tick_nx    = step_tick ? '0 : tick_cnt + 1'b1;
      score_nx   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
      acc_nx     = acc_sum >= AW'(LEVEL_STEP) ? acc_sum - AW'(LEVEL_STEP) : acc_sum;
      level_nx   = acc_sum >= AW'(LEVEL_STEP) && level != 3'(MAX_LEVEL) ? level + 3'd1 : level;
    end
    if (|grant_nx) begin
      pattern_nx = pat;
      lfsr_nx    = lfsr_adv;
    end
  end

  // state and output registers
  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      pattern_out <= '0;
      pending     <= '0;
      rr_ptr      <= '0;
      load_idx    <= '0;
      lfsr        <= LFSR_SEED;
      tick_cnt    <= '0;
      lvl_acc     <= '0;
      score       <= '0;
      level       <= '0;
    end else begin
      state       <= state_nx;
      grant       <= grant_nx;
      pattern_out <= pattern_nx;
      pending     <= pending_nx;
      rr_ptr      <= rr_nx;
      load_idx    <= load_nx;
      lfsr        <= lfsr_nx;
      tick_cnt    <= tick_nx;
      lvl_acc     <= acc_nx;
      score       <= score_nx;
      level       <= level_nx;
    end
  end
endmodule
